digiled_frame_sequencer: RTL and testbench

Frame scheduler between the DigiLED AXI4-Lite register bank/pixel RAM and the WS2812-style bit serializer. It fetches one 24-bit pixel per LED from the pixel RAM and hands it to the serializer over a valid/ready stream. After the last pixel it waits for the line to drain, then enforces the latch (reset) low-time. It repeats frames at a programmed refresh period or runs single frames on software request.

---
 rtl/digiled_pkg.sv | 7 +
 rtl/digiled_interval_timer.sv | 20 ++
 rtl/digiled_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_digiled_frame_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digiled_pkg.sv
// digiled_pkg: shared types and defaults for the DigiLED frame sequencer
package digiled_pkg;
  localparam int PIX_W_DEF = 24;
  localparam int LATCH_CYCLES_DEF = 6000;
  localparam int FC_W = 16;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, PRESENT, DRAIN, LATCH, HOLDOFF} state_t;
endpackage

// File: rtl/digiled_interval_timer.sv
// digiled_interval_timer: loadable down-counter that saturates at zero and flags expiry
// Ports: clk, rst_n (sync active-low), load/load_val (restart), en (count), expired (count is zero)
module digiled_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired = cnt_q == '0;
endmodule

// File: rtl/digiled_frame_sequencer.sv
// digiled_frame_sequencer: fetches pixels from pixel RAM, streams them to the serializer, then drains and latches
// Ports: s00_axi_aclk/s00_axi_aresetn (sync active-low); cfg_* frame configuration;
//   mem_rd_en/mem_addr/mem_rdata pixel RAM read port; pix_data/pix_valid/pix_ready serializer stream;
//   ser_busy serializer shifting; latch_active, busy, frame_done, frame_count status.
// Option DIGILED_PINGPONG_EN adds cfg_swap_req/active_bank and widens mem_addr by the bank bit.
module digiled_frame_sequencer
  import digiled_pkg::*;
#(
  parameter int MAX_LEDS = 256,
  parameter int PIX_W = PIX_W_DEF,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF,
  parameter int REFRESH_W = 24,
  localparam int ADDR_W = $clog2(MAX_LEDS)
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 cfg_enable,
  input  logic                 cfg_start,
  input  logic [ADDR_W:0]      cfg_led_count,
  input  logic [REFRESH_W-1:0] cfg_refresh_cycles,
`ifdef DIGILED_PINGPONG_EN
  input  logic                 cfg_swap_req,
  output logic                 active_bank,
  output logic [ADDR_W:0]      mem_addr,
`else
  output logic [ADDR_W-1:0]    mem_addr,
`endif
  output logic                 mem_rd_en,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  input  logic                 ser_busy,
  output logic                 latch_active,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FC_W-1:0]      frame_count
);
  localparam int CW = ADDR_W + 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d, cnt_clamp;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic done_q, done_d;
  logic start, lat_load, lat_exp, ref_exp;
  logic [REFRESH_W-1:0] ref_load;
  always_comb begin
    cnt_clamp = cfg_led_count > CW'(MAX_LEDS) ? CW'(MAX_LEDS) : cfg_led_count;
    ref_load = cfg_refresh_cycles == '0 ? '0 : cfg_refresh_cycles - 1'b1;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    pix_d = pix_q;
    fc_d = fc_q;
    done_d = 1'b0;
    start = 1'b0;
    lat_load = 1'b0;
    case (state_q)
      IDLE: start = (cfg_enable || cfg_start) && cnt_clamp != '0;
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        pix_d = mem_rdata;
        state_d = PRESENT;
      end
      PRESENT: if (pix_ready) begin
        idx_d = idx_q + 1'b1;
        state_d = idx_q == cnt_q - 1'b1 ? DRAIN : FETCH;
      end
      DRAIN: if (!ser_busy) begin
        lat_load = 1'b1;
        state_d = LATCH;
      end
      LATCH: if (lat_exp) begin
        done_d = 1'b1;
        fc_d = fc_q + 1'b1;
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (!cfg_enable || cnt_clamp == '0) state_d = IDLE;
        else start = ref_exp;
      end
      default: state_d = IDLE;
    endcase
    // Frame start: snapshot count; the refresh timer load snapshots the period.
    if (start) begin
      state_d = FETCH;
      idx_d = '0;
      cnt_d = cnt_clamp;
    end
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      pix_q <= '0;
      fc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      pix_q <= pix_d;
      fc_q <= fc_d;
      done_q <= done_d;
    end
  end
  digiled_interval_timer #(.W(LW)) u_latch (
    .clk(s00_axi_aclk), .rst_n(s00_axi_aresetn), .load(lat_load), .en(state_q == LATCH),
    .load_val(LW'(LATCH_CYCLES - 1)), .expired(lat_exp)
  );
  digiled_interval_timer #(.W(REFRESH_W)) u_refresh (
    .clk(s00_axi_aclk), .rst_n(s00_axi_aresetn), .load(start), .en(1'b1),
    .load_val(ref_load), .expired(ref_exp)
  );
`ifdef DIGILED_PINGPONG_EN
  logic bank_q, bank_d;
  always_comb bank_d = start && cfg_swap_req ? ~bank_q : bank_q;
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) bank_q <= 1'b0;
    else bank_q <= bank_d;
  end
  assign active_bank = bank_q;
  assign mem_addr = {bank_q, idx_q[ADDR_W-1:0]};
`else
  assign mem_addr = idx_q[ADDR_W-1:0];
`endif
  assign mem_rd_en = state_q == FETCH;
  assign pix_valid = state_q == PRESENT;
  assign latch_active = state_q == LATCH;
  assign busy = state_q != IDLE && state_q != HOLDOFF;
  assign pix_data = pix_q;
  assign frame_done = done_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_digiled_frame_sequencer.sv
// tb_digiled_frame_sequencer: directed self-checking bench for the DigiLED frame sequencer
module tb_digiled_frame_sequencer;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic cfg_enable = 1'b0, cfg_start = 1'b0;
  logic [8:0] cfg_led_count = '0;
  logic [23:0] cfg_refresh_cycles = '0;
  logic mem_rd_en;
`ifdef DIGILED_PINGPONG_EN
  logic cfg_swap_req = 1'b0;
  logic active_bank;
  logic [8:0] mem_addr;
`else
  logic [7:0] mem_addr;
`endif
  logic [23:0] mem_rdata = '0;
  logic [23:0] pix_data;
  logic pix_valid, latch_active, busy, frame_done;
  logic pix_ready = 1'b1, ser_busy = 1'b0;
  logic [15:0] frame_count;
  logic [23:0] ram [256];
  int checks = 0, errors = 0;
  int cyc = 0;
  int rd_cnt = 0, lat_cnt = 0, done_cnt = 0, last_done_cyc = 0, lat_rise_cyc = 0;
  logic lat_prev = 1'b0;
  logic [23:0] hs_data[$];
  int hs_cyc[$];
  int rd_addr[$];
  int exp_fc = 0;

  digiled_frame_sequencer dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .cfg_enable(cfg_enable), .cfg_start(cfg_start),
    .cfg_led_count(cfg_led_count), .cfg_refresh_cycles(cfg_refresh_cycles),
`ifdef DIGILED_PINGPONG_EN
    .cfg_swap_req(cfg_swap_req), .active_bank(active_bank),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ser_busy(ser_busy), .latch_active(latch_active), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr[7:0]];

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_addr.push_back(int'(mem_addr[7:0]));
    end
    if (pix_valid && pix_ready) begin
      hs_data.push_back(pix_data);
      hs_cyc.push_back(cyc);
    end
    if (latch_active) lat_cnt <= lat_cnt + 1;
    if (latch_active && !lat_prev) lat_rise_cyc <= cyc;
    lat_prev <= latch_active;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = frame_done;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step(3);
    checks++;
    if ({mem_rd_en, pix_valid, latch_active, busy, frame_done, mem_addr, pix_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b valid=%b latch=%b busy=%b done=%b addr=%0d data=%h, want all 0",
               mem_rd_en, pix_valid, latch_active, busy, frame_done, mem_addr, pix_data);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
    aresetn = 1'b1;
    step(2);
  endtask

  task automatic test_single_frame();
    int h0, r0, l0, d0;
    bit ok;
    h0 = hs_data.size(); r0 = rd_cnt; l0 = lat_cnt; d0 = done_cnt;
    cfg_led_count = 9'd3;
    pulse_start();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL single_first_fetch: rd=%b addr=%0d want rd=1 addr=0", mem_rd_en, mem_addr);
    end
    wait_done(7000, ok);
    exp_fc++;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_timeout: no frame_done within 7000 cycles");
    end
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL single_frame_count: got %0d want %0d", frame_count, exp_fc);
    end
    step(3);
    checks++;
    if (hs_data.size() - h0 != 3 || hs_data[h0] !== 24'h0000FF || hs_data[h0+1] !== 24'h00FF00 || hs_data[h0+2] !== 24'hFF0000) begin
      errors++;
      $display("FAIL single_pixels: got %0d handshakes, first=%h second=%h third=%h want 3 of 0000ff 00ff00 ff0000",
               hs_data.size() - h0, hs_data[h0], hs_data[h0+1], hs_data[h0+2]);
    end
    checks++;
    if (rd_cnt - r0 != 3 || rd_addr[r0] != 0 || rd_addr[r0+1] != 1 || rd_addr[r0+2] != 2) begin
      errors++;
      $display("FAIL single_reads: got %0d reads want 3 at addresses 0,1,2", rd_cnt - r0);
    end
    checks++;
    if (hs_cyc[h0+1] - hs_cyc[h0] != 3) begin
      errors++;
      $display("FAIL single_latency: handshake spacing %0d want 3", hs_cyc[h0+1] - hs_cyc[h0]);
    end
    checks++;
    if (lat_cnt - l0 != 6000) begin
      errors++;
      $display("FAIL single_latch_len: got %0d cycles want 6000", lat_cnt - l0);
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: done pulses %0d busy=%b rd=%b want 1,0,0", done_cnt - d0, busy, mem_rd_en);
    end
  endtask

  task automatic test_backpressure();
    int h0, r1, bad;
    bit ok, seen;
    h0 = hs_data.size();
    cfg_led_count = 9'd2;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hs_data.size() > h0;
    end
    step(1);
    pix_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pix_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid_timeout: pixel 1 never presented");
    end
    r1 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_valid !== 1'b1 || pix_data !== 24'h00FF00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles of 50, want 0", bad);
    end
    checks++;
    if (rd_cnt != r1) begin
      errors++;
      $display("FAIL bp_no_extra_read: %0d reads during stall want 0", rd_cnt - r1);
    end
    step(1);
    pix_ready = 1'b1;
    wait_done(7000, ok);
    exp_fc++;
    step(1);
    checks++;
    if (!ok || hs_data.size() - h0 != 2 || hs_data[h0+1] !== 24'h00FF00 || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL bp_complete: done=%b handshakes=%0d count=%0d want 1,2,%0d", ok, hs_data.size() - h0, frame_count, exp_fc);
    end
  endtask

  task automatic test_drain();
    int h0, l0, f;
    bit ok, seen;
    h0 = hs_data.size(); l0 = lat_cnt;
    cfg_led_count = 9'd1;
    ser_busy = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hs_data.size() > h0;
    end
    step(200);
    checks++;
    if (!seen || lat_cnt != l0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold: handshake=%b latch cycles=%0d busy=%b want 1,0,1", seen, lat_cnt - l0, busy);
    end
    ser_busy = 1'b0;
    f = cyc;
    wait_done(7000, ok);
    exp_fc++;
    step(1);
    checks++;
    if (lat_rise_cyc != f + 1) begin
      errors++;
      $display("FAIL drain_latch_rise: latch rose %0d cycles after ser_busy fell want 1", lat_rise_cyc - f);
    end
    checks++;
    if (!ok || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL drain_done: done=%b count=%0d want 1,%0d", ok, frame_count, exp_fc);
    end
  endtask

  task automatic test_refresh();
    int d1, r0;
    bit ok;
    cfg_led_count = 9'd2;
    cfg_refresh_cycles = 24'd20000;
    cfg_enable = 1'b1;
    wait_done(8000, ok);
    exp_fc++;
    step(1);
    d1 = last_done_cyc;
    cfg_refresh_cycles = 24'd100;
    wait_done(21000, ok);
    exp_fc++;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL refresh_timeout: second frame_done missing");
    end
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL refresh_restart: rd=%b addr=%0d one cycle after frame_done want rd=1 addr=0", mem_rd_en, mem_addr);
    end
    step(1);
    checks++;
    if (last_done_cyc - d1 != 20000) begin
      errors++;
      $display("FAIL refresh_period: frame_done spacing %0d want 20000", last_done_cyc - d1);
    end
    cfg_enable = 1'b0;
    wait_done(7000, ok);
    exp_fc++;
    step(1);
    r0 = rd_cnt;
    checks++;
    if (!ok || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL disable_finish: done=%b count=%0d want 1,%0d", ok, frame_count, exp_fc);
    end
    step(300);
    checks++;
    if (rd_cnt != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle: %0d reads busy=%b after disable want 0,0", rd_cnt - r0, busy);
    end
  endtask

  task automatic test_zero_and_clamp();
    int r0, d0, h0;
    bit ok;
    r0 = rd_cnt; d0 = done_cnt;
    cfg_led_count = 9'd0;
    pulse_start();
    step(20);
    checks++;
    if (rd_cnt != r0 || done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: reads=%0d done=%0d busy=%b want 0,0,0", rd_cnt - r0, done_cnt - d0, busy);
    end
    h0 = hs_data.size();
    cfg_led_count = 9'd300;
    pulse_start();
    wait_done(8000, ok);
    exp_fc++;
    step(1);
    checks++;
    if (!ok || hs_data.size() - h0 != 256 || rd_cnt - r0 != 256) begin
      errors++;
      $display("FAIL clamp_len: done=%b handshakes=%0d reads=%0d want 1,256,256", ok, hs_data.size() - h0, rd_cnt - r0);
    end
    checks++;
    if (rd_addr[rd_addr.size()-1] != 255 || hs_data[hs_data.size()-1] !== ram[255]) begin
      errors++;
      $display("FAIL clamp_last: addr=%0d data=%h want 255 %h", rd_addr[rd_addr.size()-1], hs_data[hs_data.size()-1], ram[255]);
    end
  endtask

  task automatic test_reset_in_latch();
    int r0;
    bit seen;
    cfg_led_count = 9'd1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = latch_active;
    end
    step(100);
    aresetn = 1'b0;
    step(1);
    checks++;
    if (!seen || {mem_rd_en, pix_valid, latch_active, busy, frame_done, mem_addr, pix_data, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_latch: in_latch=%b latch=%b busy=%b done=%b count=%0d data=%h want 1 then all 0",
               seen, latch_active, busy, frame_done, frame_count, pix_data);
    end
    aresetn = 1'b1;
    r0 = rd_cnt;
    step(10);
    checks++;
    if (busy !== 1'b0 || rd_cnt != r0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_latch_idle: busy=%b reads=%0d done=%b want 0,0,0", busy, rd_cnt - r0, frame_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 24'((i * 32'h010203) ^ 32'h5A5A5A);
    ram[0] = 24'h0000FF;
    ram[1] = 24'h00FF00;
    ram[2] = 24'hFF0000;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_drain();
    test_refresh();
    test_zero_and_clamp();
    test_reset_in_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
